// File: rtl/count_event_unit.sv
// count_event_unit
//   Watches the user-project counter, raises compare and wrap events, captures
//   count snapshots into a small FIFO and signals maskable interrupts. Software
//   configures and drains the block over a Wishbone slave port.
//
// Register map (byte offset = adr[4:2]*4):
//   0x00 CTRL   RW  [0] cmp0_en [1] cmp1_en [2] wrap_en [3] cap_en [6:4] irq_en
//   0x04 STATUS     [3:0] sticky W1C {ovf, wrap, cmp1, cmp0}
//                   [8] empty [9] full [15:12] level (read only)
//   0x08 CMP0   RW
//   0x0C CMP1   RW
//   0x10 FIFO   RO  head of snapshot FIFO; reading pops it
//   0x14 COUNT  RO  registered count
module count_event_unit #(
  parameter int          BITS      = 32,
  parameter int          DEPTH     = 8,
  parameter logic [23:0] ADDR_BASE = 24'h300001
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count,
  output logic [2:0]      irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CMP0   = 3'd2;
  localparam logic [2:0] OFF_CMP1   = 3'd3;
  localparam logic [2:0] OFF_FIFO   = 3'd4;
  localparam logic [2:0] OFF_COUNT  = 3'd5;

  // ---------------------------------------------------------------------------
  // Bus handshake
  //   A request is present while cyc & stb are high and adr[31:8] matches the
  //   block base with a mapped offset. The slave answers one cycle later with
  //   a single-cycle ack and then holds ack low for at least one cycle. The
  //   clock edge that closes the ack cycle is the single commit point: writes,
  //   W1C clears and FIFO pops happen there, exactly once per transfer.
  //   Unmapped requests are never acked; the SoC bus timeout handles them.
  // ---------------------------------------------------------------------------
  logic        addr_hit;
  logic [2:0]  reg_off;
  logic        off_mapped;
  logic        req;
  logic        commit;
  logic        wr_commit;
  logic        rd_commit;
  logic [31:0] be_mask;

  assign addr_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE);
  assign reg_off    = wbs_adr_i[4:2];
  assign off_mapped = (reg_off <= OFF_COUNT);
  assign req        = addr_hit & off_mapped;
  assign commit     = wbs_ack_o & req;
  assign wr_commit  = commit & wbs_we_i;
  assign rd_commit  = commit & ~wbs_we_i;
  assign be_mask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  // Ack pulses for one cycle after a request, then rests for one cycle
  always_ff @(posedge clk) begin
    if (reset) wbs_ack_o <= 1'b0;
    else       wbs_ack_o <= req & ~wbs_ack_o;
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [6:0]      ctrl;
  logic [BITS-1:0] cmp0;
  logic [BITS-1:0] cmp1;

  logic cmp0_en, cmp1_en, wrap_en, cap_en;
  logic [2:0] irq_en;

  assign cmp0_en = ctrl[0];
  assign cmp1_en = ctrl[1];
  assign wrap_en = ctrl[2];
  assign cap_en  = ctrl[3];
  assign irq_en  = ctrl[6:4];

  // CTRL and compare registers, written with byte enables on the commit edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      cmp0 <= '0;
      cmp1 <= '0;
    end else if (wr_commit) begin
      if (reg_off == OFF_CTRL)
        ctrl <= (ctrl & ~be_mask[6:0]) | (wbs_dat_i[6:0] & be_mask[6:0]);
      if (reg_off == OFF_CMP0)
        cmp0 <= (cmp0 & ~be_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & be_mask[BITS-1:0]);
      if (reg_off == OFF_CMP1)
        cmp1 <= (cmp1 & ~be_mask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & be_mask[BITS-1:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Event detection
  //   count_q is the sampled counter; count_prev is the sample before it and
  //   is used to recognise the all-ones -> zero wrap. A compare event fires
  //   on entry into a match, so a stalled counter produces a single event and
  //   turning on cmpN_en while already matching also produces one.
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] count_q;
  logic [BITS-1:0] count_prev;
  logic            match0_q;
  logic            match1_q;

  logic match0, match1;
  logic ev0, ev1, wrap_ev;

  assign match0  = cmp0_en & (count_q == cmp0);
  assign match1  = cmp1_en & (count_q == cmp1);
  assign ev0     = match0 & ~match0_q;
  assign ev1     = match1 & ~match1_q;
  assign wrap_ev = wrap_en & (count_q == '0) & (count_prev == '1);

  // Count sampling and match history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      count_prev <= '0;
      match0_q   <= 1'b0;
      match1_q   <= 1'b0;
    end else begin
      count_q    <= count;
      count_prev <= count_q;
      match0_q   <= match0;
      match1_q   <= match1;
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot FIFO
  //   Pop is applied before push, so a full FIFO that is popped in the same
  //   cycle as a capture accepts the new entry without overflowing. A capture
  //   into a full FIFO with no pop is dropped and flagged as overflow.
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic fifo_empty, fifo_full;
  logic push_req, push, pop, ovf_ev;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));
  assign pop        = rd_commit & (reg_off == OFF_FIFO) & ~fifo_empty;
  assign push_req   = cap_en & (ev0 | ev1);
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_ev     = push_req & fifo_full & ~pop;

  // FIFO storage; contents need no reset since level guards every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= count_q;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Status and interrupts
  // ---------------------------------------------------------------------------
  logic [3:0] status;
  logic [3:0] status_set;
  logic [3:0] status_clr;

  assign status_set = {ovf_ev, wrap_ev, ev1, ev0};
  assign status_clr = (wr_commit && reg_off == OFF_STATUS) ? wbs_dat_i[3:0] : 4'b0;

  // Sticky status: a new event outranks a same-cycle W1C of the same bit
  always_ff @(posedge clk) begin
    if (reset) status <= '0;
    else       status <= (status & ~status_clr) | status_set;
  end

  // Interrupt lines, registered from the sticky status and FIFO occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= '0;
    end else begin
      irq[0] <= irq_en[0] & status[0];
      irq[1] <= irq_en[1] & status[1];
      irq[2] <= irq_en[2] & (status[2] | status[3] | ~fifo_empty);
    end
  end

  // ---------------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------------
  logic [31:0] rdata;
  logic [3:0]  level_field;

  assign level_field = 4'(level);

  // Read mux for the addressed register; only driven out while ack is high
  always_comb begin
    rdata = '0;
    case (reg_off)
      OFF_CTRL:   rdata = {25'b0, ctrl};
      OFF_STATUS: rdata = {16'b0, level_field, 2'b0, fifo_full, fifo_empty, 4'b0, status};
      OFF_CMP0:   rdata = 32'(cmp0);
      OFF_CMP1:   rdata = 32'(cmp1);
      OFF_FIFO:   rdata = fifo_empty ? 32'h0 : 32'(mem[rd_ptr]);
      OFF_COUNT:  rdata = 32'(count_q);
      default:    rdata = '0;
    endcase
  end

  assign wbs_dat_o = wbs_ack_o ? rdata : 32'h0;

  // Address bits that do not take part in decoding
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_count_event_unit.sv
// tb_count_event_unit
//   Table-driven register vectors, directed multi-cycle sequences and a
//   randomized phase, all checked every cycle against a queue-based model.
module tb_count_event_unit;

  localparam int          BITS  = 32;
  localparam int          DEPTH = 8;
  localparam logic [23:0] BASE  = 24'h300001;

  localparam logic [2:0] O_CTRL   = 3'd0;
  localparam logic [2:0] O_STATUS = 3'd1;
  localparam logic [2:0] O_CMP0   = 3'd2;
  localparam logic [2:0] O_CMP1   = 3'd3;
  localparam logic [2:0] O_FIFO   = 3'd4;
  localparam logic [2:0] O_COUNT  = 3'd5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [31:0] cnt;
  logic [2:0]  irq;

  always #5 clk = ~clk;

  count_event_unit #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .count(cnt), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [6:0]  m_ctrl = '0;
  logic [31:0] m_cmp0 = '0, m_cmp1 = '0;
  logic [3:0]  m_stat = '0;
  logic [31:0] m_q[$];
  logic [31:0] m_cq = '0, m_prev = '0;
  bit          m_in0 = 0, m_in1 = 0, m_ack = 0;
  logic [2:0]  m_irq = '0;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] o);
    logic [31:0] r;
    int lvl;
    lvl = m_q.size();
    r = 32'h0;
    case (o)
      O_CTRL:   r = {25'b0, m_ctrl};
      O_STATUS: begin
        r = 32'(lvl) << 12;
        if (lvl == DEPTH) r = r | 32'h200;
        if (lvl == 0)     r = r | 32'h100;
        r = r | {28'b0, m_stat};
      end
      O_CMP0:   r = m_cmp0;
      O_CMP1:   r = m_cmp1;
      O_FIFO:   r = (lvl > 0) ? m_q[0] : 32'h0;
      O_COUNT:  r = m_cq;
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  function automatic void model_step();
    bit          req_ok, xfer, hit0, hit1, ev0, ev1, wrp, pop, ovf;
    logic [2:0]  o, nirq;
    logic [3:0]  w1c;
    logic [31:0] tmp;
    if (reset) begin
      m_ctrl = '0; m_cmp0 = '0; m_cmp1 = '0; m_stat = '0; m_q.delete();
      m_cq = '0; m_prev = '0; m_in0 = 0; m_in1 = 0; m_ack = 0; m_irq = '0;
      return;
    end
    o      = adr[4:2];
    req_ok = cyc && stb && (adr[31:8] == BASE) && (o <= 3'd5);
    xfer   = m_ack && req_ok;
    hit0   = m_ctrl[0] && (m_cq == m_cmp0);
    hit1   = m_ctrl[1] && (m_cq == m_cmp1);
    ev0    = hit0 && !m_in0;
    ev1    = hit1 && !m_in1;
    wrp    = m_ctrl[2] && (m_cq == 32'h0) && (m_prev == 32'hFFFF_FFFF);
    nirq[0] = m_ctrl[4] && m_stat[0];
    nirq[1] = m_ctrl[5] && m_stat[1];
    nirq[2] = m_ctrl[6] && (m_stat[2] || m_stat[3] || m_q.size() > 0);
    pop = xfer && !we && (o == O_FIFO) && (m_q.size() > 0);
    ovf = 0;
    if (pop) void'(m_q.pop_front());
    if (m_ctrl[3] && (ev0 || ev1)) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_cq);
      else ovf = 1;
    end
    w1c = (xfer && we && o == O_STATUS) ? dat_i[3:0] : 4'h0;
    m_stat = (m_stat & ~w1c) | {ovf, wrp, ev1, ev0};
    if (xfer && we) begin
      case (o)
        O_CTRL: begin tmp = bmerge({25'b0, m_ctrl}, dat_i, sel); m_ctrl = tmp[6:0]; end
        O_CMP0: m_cmp0 = bmerge(m_cmp0, dat_i, sel);
        O_CMP1: m_cmp1 = bmerge(m_cmp1, dat_i, sel);
        default: ;
      endcase
    end
    m_in0  = hit0;
    m_in1  = hit1;
    m_prev = m_cq;
    m_cq   = cnt;
    m_ack  = req_ok && !m_ack;
    m_irq  = nirq;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("ack", {31'b0, ack}, {31'b0, m_ack});
    check("irq", {29'b0, irq}, {29'b0, m_irq});
    check("dat_o", dat_o, m_ack ? model_read(adr[4:2]) : 32'h0);
  endtask

  task automatic bus(input bit w, input logic [2:0] o, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = 32'h0;
    adr = {BASE, 3'b0, o, 2'b0}; we = w; dat_i = d; sel = s; cyc = 1; stb = 1;
    for (int i = 0; i < 4 && !got; i++) begin
      cycle();
      if (ack) got = 1;
    end
    if (got) begin
      rd = dat_o;
      cycle();
    end else begin
      n_checks++;
      $display("FAIL bus_timeout: got no ack expected ack within 4 cycles (off %0d)", o);
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    logic [31:0] v;
    bus(1'b1, o, d, 4'hF, v);
  endtask

  task automatic rd(input logic [2:0] o, input logic [31:0] exp, input string name);
    logic [31:0] v;
    bus(1'b0, o, 32'h0, 4'h0, v);
    check(name, v, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          we;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    tbl[0]  = '{1'b0, O_CTRL,   32'h0,        4'h0, 32'h0000_0000};
    tbl[1]  = '{1'b0, O_STATUS, 32'h0,        4'h0, 32'h0000_0100};
    tbl[2]  = '{1'b0, O_FIFO,   32'h0,        4'h0, 32'h0000_0000};
    tbl[3]  = '{1'b0, O_STATUS, 32'h0,        4'h0, 32'h0000_0100};
    tbl[4]  = '{1'b0, O_COUNT,  32'h0,        4'h0, 32'h0000_0000};
    tbl[5]  = '{1'b0, O_CMP0,   32'h0,        4'h0, 32'h0000_0000};
    tbl[6]  = '{1'b1, O_CMP0,   32'hAABB_CCDD, 4'hF, 32'h0};
    tbl[7]  = '{1'b0, O_CMP0,   32'h0,        4'h0, 32'hAABB_CCDD};
    tbl[8]  = '{1'b1, O_CMP0,   32'h1122_3344, 4'h5, 32'h0};
    tbl[9]  = '{1'b0, O_CMP0,   32'h0,        4'h0, 32'hAA22_CC44};
    tbl[10] = '{1'b1, O_CTRL,   32'h0000_FF30, 4'h1, 32'h0};
    tbl[11] = '{1'b0, O_CTRL,   32'h0,        4'h0, 32'h0000_0030};
    tbl[12] = '{1'b1, O_CTRL,   32'h0,        4'hF, 32'h0};
    tbl[13] = '{1'b0, O_CTRL,   32'h0,        4'h0, 32'h0000_0000};
    tbl[14] = '{1'b1, O_CMP1,   32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[15] = '{1'b0, O_CMP1,   32'h0,        4'h0, 32'hFFFF_FFFF};
    tbl[16] = '{1'b1, O_STATUS, 32'h0000_000F, 4'hF, 32'h0};
    tbl[17] = '{1'b0, O_STATUS, 32'h0,        4'h0, 32'h0000_0100};

    // Reset state
    reset = 1; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0; cnt = 0;
    repeat (3) cycle();
    check("reset ack", {31'b0, ack}, 32'h0);
    check("reset dat_o", dat_o, 32'h0);
    check("reset irq", {29'b0, irq}, 32'h0);
    reset = 0;
    cycle();

    // Register vectors
    for (int i = 0; i < NV; i++) begin
      bus(tbl[i].we, tbl[i].off, tbl[i].wdata, tbl[i].sel, v);
      if (!tbl[i].we) check($sformatf("vec%0d", i), v, tbl[i].exp);
    end

    // Unmapped base and unmapped offset get no ack
    adr = {BASE ^ 24'h000010, 8'h00}; cyc = 1; stb = 1;
    repeat (3) cycle();
    check("unmapped base ack", {31'b0, ack}, 32'h0);
    adr = {BASE, 3'b0, 3'd6, 2'b0};
    repeat (3) cycle();
    check("unmapped off ack", {31'b0, ack}, 32'h0);
    cyc = 0; stb = 0;
    cycle();

    // Compare 0 on a ramp: status two clocks after count, irq one more
    wr(O_CMP0, 32'd5);
    wr(O_CTRL, 32'h19);
    for (int k = 0; k <= 10; k++) begin
      cnt = k;
      cycle();
      if (k == 6) check("t2 irq0 not yet", {31'b0, irq[0]}, 32'h0);
      if (k == 7) check("t2 irq0 set", {31'b0, irq[0]}, 32'h1);
    end
    rd(O_STATUS, 32'h0000_1001, "t2 status");
    rd(O_FIFO, 32'd5, "t2 fifo");
    wr(O_STATUS, 32'h1);
    repeat (2) cycle();
    check("t2 irq0 cleared", {31'b0, irq[0]}, 32'h0);

    // Stalled count produces a single event
    cnt = 5;
    repeat (20) cycle();
    rd(O_STATUS, 32'h0000_1001, "t3 status one entry");
    rd(O_FIFO, 32'd5, "t3 fifo");
    rd(O_STATUS, 32'h0000_0101, "t3 status empty");
    wr(O_STATUS, 32'hF);

    // Wrap detection, and no wrap from a non all-ones value
    wr(O_CTRL, 32'h44);
    cnt = 32'hFFFF_FFFE; cycle();
    cnt = 32'hFFFF_FFFF; cycle();
    cnt = 32'h0;         cycle();
    cnt = 32'h1;         cycle();
    repeat (3) cycle();
    check("t4 irq2 set", {31'b0, irq[2]}, 32'h1);
    rd(O_STATUS, 32'h0000_0104, "t4 status wrap");
    wr(O_STATUS, 32'h4);
    repeat (2) cycle();
    check("t4 irq2 cleared", {31'b0, irq[2]}, 32'h0);
    cnt = 7; repeat (2) cycle();
    cnt = 0; repeat (3) cycle();
    rd(O_STATUS, 32'h0000_0100, "t4 no false wrap");

    // Overflow: nine captures into an eight-entry FIFO
    wr(O_CTRL, 32'h09);
    cnt = 0; cycle();
    for (int i = 0; i < 9; i++) begin
      wr(O_CMP0, 32'h100 + i);
      cnt = 32'h100 + i; repeat (2) cycle();
      cnt = 0; cycle();
    end
    rd(O_STATUS, 32'h0000_8209, "t5 full ovf");
    for (int i = 0; i < 8; i++) rd(O_FIFO, 32'h100 + i, $sformatf("t5 pop%0d", i));
    rd(O_FIFO, 32'h0, "t5 empty read");
    rd(O_STATUS, 32'h0000_0109, "t5 status after drain");
    wr(O_STATUS, 32'hF);

    // Full FIFO: pop and capture in the same cycle
    for (int i = 0; i < 8; i++) begin
      wr(O_CMP0, 32'h100 + i);
      cnt = 32'h100 + i; repeat (2) cycle();
      cnt = 0; cycle();
    end
    rd(O_STATUS, 32'h0000_8201, "t6 full no ovf");
    wr(O_CMP0, 32'h200);
    cnt = 32'h200;
    rd(O_FIFO, 32'h100, "t6 pop with push");
    rd(O_STATUS, 32'h0000_8201, "t6 level kept");
    for (int i = 1; i < 8; i++) rd(O_FIFO, 32'h100 + i, $sformatf("t6 pop%0d", i));
    rd(O_FIFO, 32'h200, "t6 pushed tail");
    rd(O_STATUS, 32'h0000_0101, "t6 drained");
    wr(O_STATUS, 32'hF);

    // Wrap event and W1C of wrap in the same cycle: set wins
    wr(O_CTRL, 32'h04);
    cnt = 32'hFFFF_FFFF; repeat (2) cycle();
    cnt = 0;
    wr(O_STATUS, 32'h4);
    rd(O_STATUS, 32'h0000_0104, "t6 set beats w1c");
    wr(O_STATUS, 32'hF);

    // Reset during a transfer
    wr(O_CTRL, 32'h44);
    wr(O_CMP0, 32'h55);
    adr = {BASE, 3'b0, O_CTRL, 2'b0}; we = 0; cyc = 1; stb = 1;
    cycle();
    check("rst mid ack up", {31'b0, ack}, 32'h1);
    reset = 1;
    cycle();
    check("rst mid ack drop", {31'b0, ack}, 32'h0);
    reset = 0; cyc = 0; stb = 0;
    cycle();
    rd(O_CTRL, 32'h0, "rst mid ctrl");
    rd(O_CMP0, 32'h0, "rst mid cmp0");
    rd(O_STATUS, 32'h0000_0100, "rst mid status");

    // Randomized traffic against the model
    for (int it = 0; it < 1500; it++) begin
      int r, k;
      logic [2:0]  o;
      logic [31:0] d;
      bit          w;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        reset = 1; cycle(); reset = 0; cycle();
      end else if (r < 24) begin
        k = $urandom_range(0, 9);
        if (k <= 5)      cnt = $urandom_range(0, 7);
        else if (k == 6) cnt = 32'hFFFF_FFFF;
        else if (k == 7) cnt = 32'h0;
        cycle();
      end else if (r < 38) begin
        o = 3'($urandom_range(0, 5));
        w = ($urandom_range(0, 2) == 0);
        case (o)
          O_CTRL:            d = $urandom;
          O_STATUS:          d = $urandom_range(0, 15);
          O_CMP0, O_CMP1:    d = $urandom_range(0, 7);
          default:           d = $urandom;
        endcase
        if ($urandom_range(0, 1) == 0) cnt = $urandom_range(0, 7);
        bus(w, o, d, 4'($urandom_range(0, 15)), d);
      end else begin
        adr = {BASE, 3'b0, 3'($urandom_range(6, 7)), 2'b0}; cyc = 1; stb = 1;
        repeat (2) cycle();
        cyc = 0; stb = 0;
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
